// File: rtl/basic_ram_arbiter_if.sv
// Bundle of requester and RAM-side signals for the two-port RAM arbiter.
//   slave  : arbiter view (samples requests and ram_rdata, drives grants/acks/strobes)
//   master : requester + RAM view (drives requests and ram_rdata)
interface basic_ram_arbiter_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 5
) ();
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          ack1;

    logic [DW-1:0] rdata;

    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_rdata,
        output gnt0, ack0, gnt1, ack1, rdata,
        output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_rdata,
        input  gnt0, ack0, gnt1, ack1, rdata,
        input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
    );
endinterface

// File: rtl/basic_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port synchronous RAM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : basic_ram_arbiter_if.slave -- req/we/addr/wdata in, gnt/ack out per
//                requester; rdata out; ram_cs/we/oe/addr/wdata out; ram_rdata in.
// All outputs are registered: the next-state logic computes the value each output
// must hold in the coming state, and the register stage presents it.
module basic_ram_arbiter #(
    parameter int unsigned DW     = 4,
    parameter int unsigned AW     = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    basic_ram_arbiter_if.slave  bus
);
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;       // owner of the current transaction
    logic          we_q, we_d;         // latched direction
    logic          last_q, last_d;     // last winner, for round-robin tie-break
    logic [CW-1:0] cnt_q, cnt_d;       // read latency countdown
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    ack_q, ack_d;
    logic          ram_cs_q, ram_cs_d;
    logic          ram_we_q, ram_we_d;
    logic          ram_oe_q, ram_oe_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        gnt_d       = 2'b00;
        ack_d       = 2'b00;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_oe_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that did not win last time goes first
                    win_d       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    we_d        = win_d ? bus.we1 : bus.we0;
                    gnt_d       = win_d ? 2'b10 : 2'b01;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = we_d;
                    ram_oe_d    = ~we_d;
                    ram_addr_d  = win_d ? bus.addr1 : bus.addr0;
                    ram_wdata_d = we_d ? (win_d ? bus.wdata1 : bus.wdata0) : '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    ack_d   = win_q ? 2'b10 : 2'b01;
                    state_d = RESP;
                end else begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    rdata_d = bus.ram_rdata;
                    ack_d   = win_q ? 2'b10 : 2'b01;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops every strobe without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            gnt_q       <= 2'b00;
            ack_q       <= 2'b00;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.rdata     = rdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_oe    = ram_oe_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule
